// File: rtl/dot_weight_loader_if.sv
// AXI4-Stream slave bundle carrying 32-bit weight words into dot_weight_loader.
interface dot_weight_loader_if;
  logic [31:0] tdata;
  logic        tlast;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/dot_weight_loader.sv
// Streams a ROWS x COLS float32 weight matrix into the dot stage, rejecting malformed frames.
// Define WLOAD_DOUBLE_BUFFER_EN for a shadow matrix committed atomically while commit_ok is high.
module dot_weight_loader #(
  parameter int ROWS = 3,
  parameter int COLS = 4
) (
  input  logic                clk,
  input  logic                rst,
  dot_weight_loader_if.slave  s_axis,
  input  logic                commit_ok,
  output logic [31:0]         weights [0:ROWS-1][0:COLS-1],
  output logic                weights_valid,
  output logic                load_done,
  output logic                frame_err,
  output logic [7:0]          err_count
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [1:0] {ST_LOAD, ST_DRAIN, ST_COMMIT} state_t;

  state_t        state_reg;
  logic [RW-1:0] r_reg;
  logic [CW-1:0] c_reg;
  logic          beat;
  logic          load_wr;
  logic          last_word;

  assign s_axis.tready = !rst && (state_reg != ST_COMMIT);
  assign beat          = s_axis.tvalid && s_axis.tready;
  assign load_wr       = beat && (state_reg == ST_LOAD);
  assign last_word     = (r_reg == RW'(ROWS - 1)) && (c_reg == CW'(COLS - 1));

`ifdef WLOAD_DOUBLE_BUFFER_EN
  logic [31:0] shadow [0:ROWS-1][0:COLS-1];
  logic        commit_fire;
  assign commit_fire = (state_reg == ST_COMMIT) && commit_ok;
`else
  logic first_word;
  logic unused_commit_ok;
  assign first_word       = (r_reg == '0) && (c_reg == '0);
  assign unused_commit_ok = commit_ok;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_LOAD;
      r_reg         <= '0;
      c_reg         <= '0;
      weights_valid <= 1'b0;
      load_done     <= 1'b0;
      frame_err     <= 1'b0;
      err_count     <= 8'd0;
    end else begin
      load_done <= 1'b0;
      frame_err <= 1'b0;
      case (state_reg)
        ST_LOAD: begin
          if (beat) begin
`ifndef WLOAD_DOUBLE_BUFFER_EN
            // The active matrix is being overwritten in place from this beat on.
            if (first_word) weights_valid <= 1'b0;
`endif
            if (last_word) begin
              r_reg <= '0;
              c_reg <= '0;
              if (s_axis.tlast) begin
`ifdef WLOAD_DOUBLE_BUFFER_EN
                state_reg <= ST_COMMIT;
`else
                weights_valid <= 1'b1;
                load_done     <= 1'b1;
`endif
              end else begin
                frame_err <= 1'b1;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                state_reg <= ST_DRAIN;
              end
            end else if (s_axis.tlast) begin
              r_reg     <= '0;
              c_reg     <= '0;
              frame_err <= 1'b1;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end else if (c_reg == CW'(COLS - 1)) begin
              c_reg <= '0;
              r_reg <= r_reg + 1'b1;
            end else begin
              c_reg <= c_reg + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (beat && s_axis.tlast) state_reg <= ST_LOAD;
        end
        ST_COMMIT: begin
`ifdef WLOAD_DOUBLE_BUFFER_EN
          if (commit_ok) begin
            weights_valid <= 1'b1;
            load_done     <= 1'b1;
            state_reg     <= ST_LOAD;
          end
`endif
        end
        default: state_reg <= ST_LOAD;
      endcase
    end
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_col
      logic sel;
      assign sel = load_wr && (r_reg == RW'(gi)) && (c_reg == CW'(gj));
`ifdef WLOAD_DOUBLE_BUFFER_EN
      // Shadow contents are only observed after a full frame, so no reset is needed.
      always_ff @(posedge clk) begin
        if (sel) shadow[gi][gj] <= s_axis.tdata;
      end

      always_ff @(posedge clk) begin
        if (rst)              weights[gi][gj] <= 32'd0;
        else if (commit_fire) weights[gi][gj] <= shadow[gi][gj];
      end
`else
      always_ff @(posedge clk) begin
        if (rst)      weights[gi][gj] <= 32'd0;
        else if (sel) weights[gi][gj] <= s_axis.tdata;
      end
`endif
    end
  end

endmodule
